// File: rtl/ls161_timer_ctrl.sv
// Sequencing controller that turns a cascade of LS161a counters into a
// programmable one-shot / periodic interval timer.
module ls161_timer_ctrl #(
   parameter int STAGES = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic                  STOP,
   input  logic                  PERIODIC,
   input  logic [4*STAGES-1:0]   RELOAD_VAL,
   input  logic                  CNT_RCO,
   output logic                  CNT_CLR_n,
   output logic                  CNT_LOAD_n,
   output logic                  CNT_ENP,
   output logic                  CNT_ENT,
   output logic [4*STAGES-1:0]   CNT_D,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [7:0]            EXP_CNT
);

   localparam int W = 4 * STAGES;

   typedef enum logic [2:0] {
      S_CLEAR  = 3'd0,
      S_IDLE   = 3'd1,
      S_LOAD   = 3'd2,
      S_RUN    = 3'd3,
      S_EXPIRE = 3'd4
   } state_t;

   state_t         state_r;
   state_t         next_s;
   logic           start_acc_s;
   logic           periodic_r;
   logic [W-1:0]   reload_r;
   logic [7:0]     exp_cnt_r;
   logic           clr_n_r;
   logic           load_n_r;
   logic           en_r;
   logic           busy_r;
   logic           done_r;

   assign start_acc_s = (state_r == S_IDLE) && !STOP && START;

   // Next-state decode; STOP wins over every other transition except out of CLEAR.
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_CLEAR:  next_s = S_IDLE;
         S_IDLE: begin
            if (STOP)       next_s = S_CLEAR;
            else if (START) next_s = S_LOAD;
            else            next_s = S_IDLE;
         end
         S_LOAD: begin
            if (STOP) next_s = S_CLEAR;
            else      next_s = S_RUN;
         end
         S_RUN: begin
            if (STOP)         next_s = S_CLEAR;
            else if (CNT_RCO) next_s = S_EXPIRE;
            else              next_s = S_RUN;
         end
         S_EXPIRE: begin
            if (STOP)            next_s = S_CLEAR;
            else if (periodic_r) next_s = S_LOAD;
            else                 next_s = S_IDLE;
         end
         default:  next_s = S_CLEAR;
      endcase
   end

   // State, latched configuration, expiry counter and outputs decoded one edge early
   // from next_s so every pin is a flop aligned with the state it belongs to.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= S_CLEAR;
         periodic_r <= 1'b0;
         reload_r   <= {W{1'b0}};
         exp_cnt_r  <= 8'd0;
         clr_n_r    <= 1'b0;
         load_n_r   <= 1'b1;
         en_r       <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r <= next_s;
         if (start_acc_s) begin
            periodic_r <= PERIODIC;
            reload_r   <= RELOAD_VAL;
            exp_cnt_r  <= 8'd0;
         end else if ((next_s == S_EXPIRE) && (exp_cnt_r != 8'hFF)) begin
            exp_cnt_r  <= exp_cnt_r + 8'd1;
         end
         clr_n_r  <= (next_s != S_CLEAR);
         load_n_r <= (next_s != S_LOAD);
         en_r     <= (next_s == S_RUN);
         busy_r   <= (next_s == S_LOAD) || (next_s == S_RUN) || (next_s == S_EXPIRE);
         done_r   <= (next_s == S_EXPIRE);
      end
   end

   assign CNT_CLR_n  = clr_n_r;
   assign CNT_LOAD_n = load_n_r;
   assign CNT_ENP    = en_r;
   assign CNT_ENT    = en_r;
   assign CNT_D      = reload_r;
   assign BUSY       = busy_r;
   assign DONE       = done_r;
   assign EXP_CNT    = exp_cnt_r;

endmodule

// File: tb/tb_ls161_timer_ctrl.sv
// Bench for ls161_timer_ctrl: models the LS161 cascade, predicts DONE cycles and
// expiry counts arithmetically and scoreboards them against the DUT.
module tb_ls161_timer_ctrl;

   localparam int STAGES = 2;
   localparam int W      = 4 * STAGES;
   localparam int M      = (1 << W) - 1;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   logic          STOP;
   logic          PERIODIC;
   logic [W-1:0]  RELOAD_VAL;
   logic          CNT_RCO;
   logic          CNT_CLR_n;
   logic          CNT_LOAD_n;
   logic          CNT_ENP;
   logic          CNT_ENT;
   logic [W-1:0]  CNT_D;
   logic          BUSY;
   logic          DONE;
   logic [7:0]    EXP_CNT;

   ls161_timer_ctrl #(.STAGES(STAGES)) dut (
      .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PERIODIC(PERIODIC),
      .RELOAD_VAL(RELOAD_VAL), .CNT_RCO(CNT_RCO), .CNT_CLR_n(CNT_CLR_n),
      .CNT_LOAD_n(CNT_LOAD_n), .CNT_ENP(CNT_ENP), .CNT_ENT(CNT_ENT),
      .CNT_D(CNT_D), .BUSY(BUSY), .DONE(DONE), .EXP_CNT(EXP_CNT)
   );

   always #5 CLK = ~CLK;

   // External LS161 cascade: asynchronous clear, synchronous load, count when enabled.
   logic [W-1:0] q;
   always_ff @(posedge CLK or negedge CNT_CLR_n) begin
      if (!CNT_CLR_n)       q <= '0;
      else if (!CNT_LOAD_n) q <= CNT_D;
      else if (CNT_ENP && CNT_ENT) q <= q + 1'b1;
   end
   assign CNT_RCO = CNT_ENT && (q == W'(M));

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct { int at; int cnt; } ev_t;
   ev_t sb[$];
   ev_t ev;

   int  checks   = 0;
   int  failures = 0;
   logic mon_en  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every DONE must match the head of the expected-expiry queue.
   always @(negedge CLK) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].at < cyc) begin
            chk("done_missed_at_cycle", cyc, sb[0].at);
            void'(sb.pop_front());
         end
         if (DONE) begin
            if (sb.size() > 0 && sb[0].at == cyc) begin
               ev = sb.pop_front();
               chk("exp_cnt_at_done", int'(EXP_CNT), ev.cnt);
            end else begin
               chk("done_unexpected", int'(DONE), 0);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
      RELOAD_VAL = W'($urandom_range(0, M));
      PERIODIC   = 1'($urandom_range(0, 1));
   endtask

   task automatic go_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic flush_after(input int c);
      while (sb.size() > 0 && sb[$].at > c) void'(sb.pop_back());
   endtask

   // Issue START in the current (IDLE) cycle; expiries predicted up to s+horizon.
   task automatic do_start(input logic [W-1:0] r, input logic per, input int horizon, output int s);
      int p;
      int k;
      ev_t e;
      s = cyc;
      p = M - int'(r) + 3;
      START = 1'b1;
      RELOAD_VAL = r;
      PERIODIC = per;
      if (per) begin
         k = 1;
         while (s + k * p <= s + horizon) begin
            e.at = s + k * p;
            e.cnt = (k > 255) ? 255 : k;
            sb.push_back(e);
            k++;
         end
      end else begin
         e.at = s + p;
         e.cnt = 1;
         sb.push_back(e);
      end
      step();
      START = 1'b0;
      @(negedge CLK);
      chk("load_n_in_load", int'(CNT_LOAD_n), 0);
      chk("cnt_d_latched", int'(CNT_D), int'(r));
      chk("exp_cnt_cleared", int'(EXP_CNT), 0);
      chk("busy_in_load", int'(BUSY), 1);
   endtask

   task automatic do_stop();
      int c;
      c = cyc;
      STOP = 1'b1;
      flush_after(c);
      step();
      STOP = 1'b0;
      @(negedge CLK);
      chk("clr_n_after_stop", int'(CNT_CLR_n), 0);
      chk("q_zero_after_stop", int'(q), 0);
      chk("busy_in_clear", int'(BUSY), 0);
      chk("done_in_clear", int'(DONE), 0);
      step();
      @(negedge CLK);
      chk("clr_n_idle", int'(CNT_CLR_n), 1);
      chk("busy_idle", int'(BUSY), 0);
      chk("load_n_idle", int'(CNT_LOAD_n), 1);
   endtask

   task automatic do_reset();
      int c;
      c = cyc;
      RST = 1'b1;
      flush_after(c);
      step();
      @(negedge CLK);
      chk("rst_clr_n_c1", int'(CNT_CLR_n), 0);
      chk("rst_q_zero", int'(q), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_exp_cnt", int'(EXP_CNT), 0);
      step();
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_clr_n_c2", int'(CNT_CLR_n), 0);
      step();
      @(negedge CLK);
      chk("post_rst_clr_n", int'(CNT_CLR_n), 1);
      chk("post_rst_busy", int'(BUSY), 0);
      chk("post_rst_done", int'(DONE), 0);
      chk("post_rst_exp_cnt", int'(EXP_CNT), 0);
      chk("post_rst_cnt_d", int'(CNT_D), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int r;
      int hz;
      logic per;
      RST = 1'b1; START = 1'b0; STOP = 1'b0; PERIODIC = 1'b0; RELOAD_VAL = '0;
      step();
      step();
      @(negedge CLK);
      chk("reset_clr_n", int'(CNT_CLR_n), 0);
      chk("reset_load_n", int'(CNT_LOAD_n), 1);
      chk("reset_enp", int'(CNT_ENP), 0);
      chk("reset_ent", int'(CNT_ENT), 0);
      chk("reset_cnt_d", int'(CNT_D), 0);
      chk("reset_busy", int'(BUSY), 0);
      chk("reset_done", int'(DONE), 0);
      chk("reset_exp_cnt", int'(EXP_CNT), 0);
      RST = 1'b0;
      step();
      @(negedge CLK);
      chk("idle_clr_n", int'(CNT_CLR_n), 1);
      chk("idle_busy", int'(BUSY), 0);
      mon_en = 1'b1;

      // One-shot R=0xF0 with an ignored START mid-run.
      do_start(8'hF0, 1'b0, 0, s);
      go_to(s + 2);
      @(negedge CLK);
      chk("run_holds_r", int'(q), 8'hF0);
      chk("run_enp", int'(CNT_ENP), 1);
      go_to(s + 4);
      START = 1'b1;
      RELOAD_VAL = 8'h33;
      step();
      START = 1'b0;
      @(negedge CLK);
      chk("start_busy_ignored_r", int'(CNT_D), 8'hF0);
      go_to(s + 19);
      @(negedge CLK);
      chk("oneshot_idle_busy", int'(BUSY), 0);
      chk("oneshot_idle_q", int'(q), 0);
      chk("oneshot_exp_cnt", int'(EXP_CNT), 1);

      // Periodic R=0xFE, stopped in RUN.
      do_start(8'hFE, 1'b1, 14, s);
      go_to(s + 14);
      do_stop();

      // Periodic R=0xFE, reset mid-RUN after three expiries.
      do_start(8'hFE, 1'b1, 14, s);
      go_to(s + 14);
      do_reset();

      // STOP during EXPIRE: DONE still pulses once.
      do_start(8'hFE, 1'b1, 8, s);
      go_to(s + 8);
      do_stop();

      // START and STOP together in IDLE.
      START = 1'b1;
      STOP = 1'b1;
      step();
      START = 1'b0;
      STOP = 1'b0;
      @(negedge CLK);
      chk("startstop_clr_n", int'(CNT_CLR_n), 0);
      chk("startstop_load_n", int'(CNT_LOAD_n), 1);
      step();
      @(negedge CLK);
      chk("startstop_idle_busy", int'(BUSY), 0);
      step();
      @(negedge CLK);
      chk("startstop_no_load", int'(CNT_LOAD_n), 1);

      // Boundaries: R=M periodic, R=0 one-shot.
      do_start(8'hFF, 1'b1, 9, s);
      go_to(s + 9);
      do_stop();
      do_start(8'h00, 1'b0, 0, s);
      go_to(s + 260);
      @(negedge CLK);
      chk("r0_idle_busy", int'(BUSY), 0);

      // Saturation over 300 periods, then a fresh START clears the count.
      do_start(8'hFF, 1'b1, 900, s);
      go_to(s + 901);
      @(negedge CLK);
      chk("exp_cnt_saturated", int'(EXP_CNT), 255);
      do_stop();
      do_start(8'h80, 1'b0, 0, s);
      go_to(s + M - 8'h80 + 5);

      // Randomized runs with random stop points.
      for (int i = 0; i < 10; i++) begin
         r   = int'($urandom_range(0, M));
         per = 1'($urandom_range(0, 1));
         hz  = int'($urandom_range(1, 3 * (M - r + 3)));
         do_start(W'(r), per, hz, s);
         go_to(s + hz);
         do_stop();
      end

      go_to(cyc + 5);
      @(negedge CLK);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ls161_timer_ctrl.md
# ls161_timer_ctrl

Sequencing controller for a cascade of `LS161a` 4-bit synchronous counters. It turns the cascade into a programmable one-shot or periodic interval timer. It drives the counters' clear, load, parallel-data and enable pins, and watches the terminal-count ripple carry (RCO) of the last stage. It reports busy/expire status and a saturating expiry count to the host logic.

## Interface
- `STAGES`, default 2: number of cascaded 4-bit counters. Timer width W = 4*STAGES; M = 2^W - 1.
- `CLK` in 1: the single clock for this block and the counter cascade.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: start request, sampled only in IDLE.
- `STOP` in 1: abort request, sampled every cycle; has priority over `START`.
- `PERIODIC` in 1: mode, latched on accepted `START` (1 = auto-reload).
- `RELOAD_VAL` in W: preset value R, latched on accepted `START`.
- `CNT_RCO` in 1: RCO of the last (most significant) counter stage.
- `CNT_CLR_n` out 1: to all stages' `CLR_n`.
- `CNT_LOAD_n` out 1: to all stages' `LOAD_n`.
- `CNT_ENP` out 1: to all stages' `ENP`.
- `CNT_ENT` out 1: to the first stage's `ENT`; later stages chain their `ENT` from the previous stage's RCO externally.
- `CNT_D` out W: latched R, nibble k drives stage k.
- `BUSY` out 1: high in LOAD, RUN and EXPIRE.
- `DONE` out 1: single-cycle expiry pulse.
- `EXP_CNT` out 8: expiries since last accepted `START`, saturates at 255.

## Operation
- The FSM has five states: CLEAR, IDLE, LOAD, RUN, EXPIRE.
- All outputs are decoded from registered state and registers only. There are no input-to-output combinational paths.
- CLEAR:
  - Outputs: `CNT_CLR_n`=0, `CNT_LOAD_n`=1, `CNT_ENP`=`CNT_ENT`=0.
  - Next state is always IDLE, unless `RST` is held.
- IDLE:
  - Outputs: `CNT_CLR_n`=1, `CNT_LOAD_n`=1, enables 0.
  - `STOP`=1 goes to CLEAR.
  - Otherwise `START`=1 latches R and mode, clears `EXP_CNT`, and goes to LOAD.
- LOAD:
  - Outputs: `CNT_LOAD_n`=0, enables 0.
  - Next state is RUN. The counter holds R in the first RUN cycle.
- RUN:
  - Outputs: `CNT_ENP`=`CNT_ENT`=1.
  - `CNT_RCO`=1 goes to EXPIRE. On that same edge the cascade wraps to 0.
  - `CNT_RCO` is ignored in every other state.
- EXPIRE:
  - Outputs: enables 0, `DONE`=1, `EXP_CNT` += 1 (saturating).
  - Next state is LOAD if the latched mode is periodic, else IDLE.
- `STOP` in LOAD, RUN or EXPIRE goes to CLEAR next cycle.
  - A `DONE` already in progress in EXPIRE still completes its one cycle.
  - `EXP_CNT` holds its value through STOP.
- `START` outside IDLE is ignored. `RELOAD_VAL` and `PERIODIC` changes outside an accepted `START` have no effect.
- `RST`=1 at any clock edge forces CLEAR, clears the R and mode registers, and clears `EXP_CNT`.
  - `CNT_CLR_n` is therefore low during reset and for one cycle after release.
  - This also holds for reset asserted mid-count.
- Reset values:
  - `CNT_CLR_n`=0, `CNT_LOAD_n`=1, `CNT_ENP`=`CNT_ENT`=0.
  - `CNT_D`=0, `BUSY`=0, `DONE`=0, `EXP_CNT`=0.

## Timing
- `START` accepted at the edge ending IDLE cycle s: LOAD is cycle s+1, RUN starts at s+2.
- RUN lasts M - R + 1 cycles (counter values R..M). EXPIRE is cycle s + 3 + M - R.
- One-shot latency from the `START` cycle to `DONE` is M - R + 3 cycles.
- Periodic `DONE` spacing is 2^W - R + 2 cycles. The minimum is 3, at R = M.
- R = M: RUN lasts 1 cycle and RCO is high immediately.
- R = 0: RUN lasts 2^W cycles.
- `STOP` accepted in cycle c: CLEAR at c+1 (counter zeroed), IDLE at c+2. `START` can be accepted from c+2.

## Test plan
- Reset, with `STAGES`=2:
  - Stimulus: `RST`=1 for 2 cycles mid-RUN, then released.
  - Required: `CNT_CLR_n`=0 through the reset cycles plus one, counter Q=0x00, then IDLE with `BUSY`=0, `DONE`=0, `EXP_CNT`=0.
- One-shot:
  - Stimulus: R=0xF0, `PERIODIC`=0, `START` pulse in cycle s.
  - Required: LOAD at s+1, `DONE` only at s+18, `EXP_CNT`=1, IDLE at s+19 with counter Q=0x00.
- Periodic:
  - Stimulus: R=0xFE, `PERIODIC`=1.
  - Required: `DONE` every 4 cycles and `EXP_CNT` counting 1, 2, 3…
  - Then `STOP` in a RUN cycle: next cycle CLEAR with Q=0x00, then IDLE with `BUSY`=0.
- Boundaries:
  - R=0xFF periodic gives `DONE` every 3 cycles.
  - R=0x00 one-shot gives `DONE` 258 cycles after `START`.
- Conflicts:
  - `START` while `BUSY`=1: ignored, latched R unchanged.
  - `START` and `STOP` together in IDLE: goes to CLEAR, no LOAD.
  - `STOP` during EXPIRE: `DONE` still pulses once, then CLEAR.
- Saturation:
  - Stimulus: R=0xFF periodic for 300 periods.
  - Required: `EXP_CNT` stops at 255. A new `START` clears it to 0.
